// File: rtl/weight_bank_pingpong.sv
// weight_bank_pingpong
// Double-buffered weight store. One bank (active_bank) serves reads to the
// PE lanes. The other bank (shadow) is preloaded beat by beat. Once the
// shadow bank is full, a swap request promotes it to active.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr_valid     preload beat valid
//   wr_data      one entry; lane p is at [p*DATA_WIDTH +: DATA_WIDTH]
//   wr_ready     shadow bank can accept a beat
//   swap         request to promote the shadow bank (honoured only when full)
//   rd_req       read one entry of the active bank
//   filter_id, channel_id, tap   read coordinates
//   rd_valid     read response strobe (one cycle after rd_req)
//   rd_weights   read data, zero when there is no response or an error
//   active_valid the active bank holds a complete set of weights
//   shadow_full  the shadow bank is completely loaded
//   active_bank  index of the bank currently serving reads
//   swap_err     pulse: swap requested while the shadow bank was not full
//   rd_err       pulse: read out of range or with no valid active bank
module weight_bank_pingpong #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_PES      = 3,
  parameter int NUM_FILTERS  = 2,
  parameter int NUM_CHANNELS = 2,
  parameter int KERNEL_SIZE  = 3,
  localparam int DEPTH = NUM_FILTERS * NUM_CHANNELS * KERNEL_SIZE,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int CHW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int TW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
  localparam int WW    = NUM_PES * DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  input  logic [WW-1:0]  wr_data,
  output logic           wr_ready,
  input  logic           swap,
  input  logic           rd_req,
  input  logic [FW-1:0]  filter_id,
  input  logic [CHW-1:0] channel_id,
  input  logic [TW-1:0]  tap,
  output logic           rd_valid,
  output logic [WW-1:0]  rd_weights,
  output logic           active_valid,
  output logic           shadow_full,
  output logic           active_bank,
  output logic           swap_err,
  output logic           rd_err
);

  // The counter carries one extra bit so that DEPTH itself is representable.
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(32'd1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CNTW-1:0] wr_cnt_r, wr_cnt_nxt_s;
  logic            active_bank_r;
  logic            active_valid_r;
  logic            rd_valid_r;
  logic [WW-1:0]   rd_weights_r;
  logic            rd_err_r;
  logic            swap_err_r;

  logic            accept_s;
  logic            swap_ok_s;
  logic            rd_in_range_s;
  logic            rd_ok_s;
  logic [AW-1:0]   rd_addr_s;
  logic [WW-1:0]   rd_word_s;

  // Bank storage is deliberately left out of reset.
  logic [WW-1:0]   bank_mem_r [2][DEPTH];

  assign wr_ready     = (state_r != ST_FULL) && !rst;
  assign shadow_full  = (state_r == ST_FULL);
  assign active_bank  = active_bank_r;
  assign active_valid = active_valid_r;
  assign rd_valid     = rd_valid_r;
  assign rd_weights   = rd_weights_r;
  assign rd_err       = rd_err_r;
  assign swap_err     = swap_err_r;

  assign accept_s  = wr_valid && wr_ready;
  assign swap_ok_s = swap && (state_r == ST_FULL);

  assign rd_in_range_s = (32'(filter_id) < NUM_FILTERS) &&
                         (32'(channel_id) < NUM_CHANNELS) &&
                         (32'(tap) < KERNEL_SIZE);
  assign rd_ok_s   = rd_req && active_valid_r && rd_in_range_s;
  assign rd_addr_s = AW'((32'(filter_id) * NUM_CHANNELS + 32'(channel_id)) * KERNEL_SIZE
                         + 32'(tap));

  // Active-bank read mux. The address is used only when it is known to be in range.
  always_comb begin
    rd_word_s = {WW{1'b0}};
    if (rd_ok_s) begin
      rd_word_s = bank_mem_r[active_bank_r][rd_addr_s];
    end else begin
      rd_word_s = {WW{1'b0}};
    end
  end

  // Write-side FSM next state and fill counter.
  always_comb begin
    state_nxt_s  = state_r;
    wr_cnt_nxt_s = wr_cnt_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
          state_nxt_s  = (DEPTH == 1) ? ST_FULL : ST_FILL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FILL: begin
        if (accept_s) begin
          wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
          state_nxt_s  = (wr_cnt_r == CNT_LAST) ? ST_FULL : ST_FILL;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_FULL: begin
        if (swap) begin
          wr_cnt_nxt_s = {CNTW{1'b0}};
          state_nxt_s  = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        wr_cnt_nxt_s = {CNTW{1'b0}};
        state_nxt_s  = ST_EMPTY;
      end
    endcase
  end

  // Control state, bank status and the registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_EMPTY;
      wr_cnt_r       <= {CNTW{1'b0}};
      active_bank_r  <= 1'b0;
      active_valid_r <= 1'b0;
      rd_valid_r     <= 1'b0;
      rd_weights_r   <= {WW{1'b0}};
      rd_err_r       <= 1'b0;
      swap_err_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wr_cnt_r     <= wr_cnt_nxt_s;
      swap_err_r   <= swap && (state_r != ST_FULL);
      // A read in the same cycle as a swap still uses the pre-swap bank.
      rd_valid_r   <= rd_req;
      rd_err_r     <= rd_req && !rd_ok_s;
      rd_weights_r <= rd_word_s;
      if (swap_ok_s) begin
        active_bank_r  <= ~active_bank_r;
        active_valid_r <= 1'b1;
      end else begin
        active_bank_r  <= active_bank_r;
        active_valid_r <= active_valid_r;
      end
    end
  end

  // Preload writes always target the shadow bank, never the active one.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      bank_mem_r[~active_bank_r][wr_cnt_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_weight_bank_pingpong.sv
module tb_weight_bank_pingpong;

  localparam int WW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [WW-1:0] wr_data;
  logic          wr_ready;
  logic          swap;
  logic          rd_req;
  logic [0:0]    filter_id;
  logic [0:0]    channel_id;
  logic [1:0]    tap;
  logic          rd_valid;
  logic [WW-1:0] rd_weights;
  logic          active_valid;
  logic          shadow_full;
  logic          active_bank;
  logic          swap_err;
  logic          rd_err;

  always #5 clk = ~clk;

  weight_bank_pingpong dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .swap(swap), .rd_req(rd_req), .filter_id(filter_id), .channel_id(channel_id),
    .tap(tap), .rd_valid(rd_valid), .rd_weights(rd_weights), .active_valid(active_valid),
    .shadow_full(shadow_full), .active_bank(active_bank), .swap_err(swap_err),
    .rd_err(rd_err)
  );

  typedef struct {
    logic          err;
    logic [WW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;

  // Reference model of both banks and the bank status.
  logic [WW-1:0] m_mem [2][12];
  logic          m_active;
  logic          m_av;
  logic          m_full;
  int            m_cnt;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Read scoreboard: each request's response is due exactly one edge later.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== 1'b1 || rd_err !== e.err || rd_weights !== e.data) begin
          bad++;
          $display("FAIL rd_resp: got valid=%b err=%b data=%h, expected valid=1 err=%b data=%h",
                   rd_valid, rd_err, rd_weights, e.err, e.data);
        end
      end else begin
        total++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_weights !== 48'd0) begin
          bad++;
          $display("FAIL rd_idle: got valid=%b err=%b data=%h, expected all zero",
                   rd_valid, rd_err, rd_weights);
        end
      end
    end
  end

  // One clock of stimulus: drive, queue the expected read, advance, update model.
  task automatic cycle(input logic wv, input logic [WW-1:0] wd, input logic sw,
                       input logic rq, input int f, input int c, input int t);
    bit   acc;
    bit   ok;
    exp_t e;
    wr_valid   = wv;
    wr_data    = wd;
    swap       = sw;
    rd_req     = rq;
    filter_id  = 1'(f);
    channel_id = 1'(c);
    tap        = 2'(t);
    acc = wv && !m_full && !rst;
    if (rq && !rst) begin
      ok     = m_av && f < 2 && c < 2 && t < 3;
      e.err  = !ok;
      e.data = 48'd0;
      if (ok) e.data = m_mem[m_active][(f * 2 + c) * 3 + t];
      e.due  = edge_cnt + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_av     = 1'b0;
      m_full   = 1'b0;
      m_cnt    = 0;
    end else if (sw && m_full) begin
      m_active = ~m_active;
      m_av     = 1'b1;
      m_full   = 1'b0;
      m_cnt    = 0;
    end else if (acc) begin
      m_mem[~m_active][m_cnt] = wd;
      m_cnt++;
      if (m_cnt == 12) m_full = 1'b1;
    end
    wr_valid = 1'b0;
    swap     = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b0) begin
      bad++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready);
    end
    repeat (2) cycle(1'b0, 48'd0, 1'b0, 1'b0, 0, 0, 0);
    total++;
    if ({active_bank, active_valid, shadow_full, rd_valid, rd_err, swap_err} !== 6'b0 ||
        rd_weights !== 48'd0) begin
      bad++;
      $display("FAIL reset_state: got bank=%b av=%b full=%b rv=%b re=%b se=%b w=%h expected 0",
               active_bank, active_valid, shadow_full, rd_valid, rd_err, swap_err, rd_weights);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready);
    end
    // No bank is valid yet, so this read must come back as an error.
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 0, 0, 0);
    cycle(1'b0, 48'd0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_fill_swap();
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, {16'(n + 200), 16'(n + 100), 16'(n)}, 1'b0, 1'b0, 0, 0, 0);
      if (n == 10) begin
        total++;
        if (shadow_full !== 1'b0 || wr_ready !== 1'b1) begin
          bad++; $display("FAIL fill_partial: got full=%b ready=%b expected 0/1", shadow_full, wr_ready);
        end
      end
    end
    total++;
    if (shadow_full !== 1'b1 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL fill_done: got full=%b ready=%b expected 1/0", shadow_full, wr_ready);
    end
    cycle(1'b0, 48'd0, 1'b1, 1'b0, 0, 0, 0);
    total++;
    if (active_bank !== 1'b1 || active_valid !== 1'b1 || wr_ready !== 1'b1 || shadow_full !== 1'b0) begin
      bad++;
      $display("FAIL swap_ok: got bank=%b av=%b ready=%b full=%b expected 1/1/1/0",
               active_bank, active_valid, wr_ready, shadow_full);
    end
  endtask

  task automatic test_read_map();
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 1, 0, 2);
    total++;
    if (rd_valid !== 1'b1 || rd_weights !== {16'd208, 16'd108, 16'd8}) begin
      bad++; $display("FAIL read_idx8: got valid=%b data=%h expected 1 00d0006c0008", rd_valid, rd_weights);
    end
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 1, 0, 3);
    total++;
    if (rd_err !== 1'b1 || rd_weights !== 48'd0) begin
      bad++; $display("FAIL read_tap3: got err=%b data=%h expected 1 0", rd_err, rd_weights);
    end
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 2; c++)
        for (int t = 0; t < 3; t++)
          cycle(1'b0, 48'd0, 1'b0, 1'b1, f, c, t);
    cycle(1'b0, 48'd0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_illegal_swap();
    for (int n = 0; n < 5; n++) cycle(1'b1, {3{16'(n + 300)}}, 1'b0, 1'b0, 0, 0, 0);
    cycle(1'b0, 48'd0, 1'b1, 1'b0, 0, 0, 0);
    total++;
    if (swap_err !== 1'b1 || active_bank !== 1'b1) begin
      bad++; $display("FAIL swap_early: got err=%b bank=%b expected 1/1", swap_err, active_bank);
    end
    cycle(1'b0, 48'd0, 1'b0, 1'b0, 0, 0, 0);
    total++;
    if (swap_err !== 1'b0) begin
      bad++; $display("FAIL swap_err_pulse: got %b expected 0", swap_err);
    end
    for (int n = 5; n < 11; n++) cycle(1'b1, {3{16'(n + 300)}}, 1'b0, 1'b0, 0, 0, 0);
    cycle(1'b1, {3{16'd311}}, 1'b1, 1'b0, 0, 0, 0);
    total++;
    if (swap_err !== 1'b1 || shadow_full !== 1'b1 || active_bank !== 1'b1) begin
      bad++;
      $display("FAIL swap_last_beat: got err=%b full=%b bank=%b expected 1/1/1",
               swap_err, shadow_full, active_bank);
    end
    cycle(1'b0, 48'd0, 1'b1, 1'b0, 0, 0, 0);
    total++;
    if (active_bank !== 1'b0 || swap_err !== 1'b0 || active_valid !== 1'b1) begin
      bad++;
      $display("FAIL swap_retry: got bank=%b err=%b av=%b expected 0/0/1", active_bank, swap_err, active_valid);
    end
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 0, 1, 1);
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 1, 1, 2);
  endtask

  task automatic test_pingpong();
    for (int n = 0; n < 12; n++) cycle(1'b1, {3{16'h0AAA}}, 1'b0, 1'b1, 0, 0, 0);
    cycle(1'b0, 48'd0, 1'b1, 1'b1, 0, 0, 0);
    total++;
    if (rd_weights !== {3{16'd300}}) begin
      bad++; $display("FAIL pingpong_pre: got %h expected 012c012c012c", rd_weights);
    end
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 0, 0, 0);
    total++;
    if (rd_weights !== {3{16'h0AAA}} || active_bank !== 1'b1) begin
      bad++; $display("FAIL pingpong_post: got %h bank=%b expected 0aaa0aaa0aaa 1", rd_weights, active_bank);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 6; n++) cycle(1'b1, {3{16'(n + 500)}}, 1'b0, 1'b1, 0, 0, 1);
    rst = 1'b1;
    cycle(1'b1, {3{16'd506}}, 1'b0, 1'b1, 0, 0, 1);
    rst = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || active_bank !== 1'b0 || active_valid !== 1'b0 || shadow_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got rv=%b bank=%b av=%b full=%b expected 0",
               rd_valid, active_bank, active_valid, shadow_full);
    end
    cycle(1'b0, 48'd0, 1'b0, 1'b1, 0, 0, 0);
    total++;
    if (rd_err !== 1'b1) begin
      bad++; $display("FAIL reset_mid_rd_err: got %b expected 1", rd_err);
    end
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, {3{16'(n + 700)}}, 1'b0, 1'b0, 0, 0, 0);
      if (n == 10) begin
        total++;
        if (shadow_full !== 1'b0) begin
          bad++; $display("FAIL refill_partial: got full=%b expected 0", shadow_full);
        end
      end
    end
    total++;
    if (shadow_full !== 1'b1) begin
      bad++; $display("FAIL refill_done: got full=%b expected 1", shadow_full);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, {3{16'hFFFF}}, 1'b0, 1'b0, 0, 0, 0);
      total++;
      if (wr_ready !== 1'b0 || shadow_full !== 1'b1) begin
        bad++; $display("FAIL backpressure: got ready=%b full=%b expected 0/1", wr_ready, shadow_full);
      end
    end
    cycle(1'b0, 48'd0, 1'b1, 1'b0, 0, 0, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 2; c++)
        for (int t = 0; t < 3; t++)
          cycle(1'b0, 48'd0, 1'b0, 1'b1, f, c, t);
    total++;
    if (rd_weights !== {3{16'd711}} || active_bank !== 1'b1) begin
      bad++; $display("FAIL backpressure_data: got %h bank=%b expected 02c702c702c7 1", rd_weights, active_bank);
    end
    repeat (2) cycle(1'b0, 48'd0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 48'd0; swap = 1'b0; rd_req = 1'b0;
    filter_id = 1'b0; channel_id = 1'b0; tap = 2'd0;
    m_active = 1'b0; m_av = 1'b0; m_full = 1'b0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_fill_swap();
    test_read_map();
    test_illegal_swap();
    test_pingpong();
    test_reset_mid();
    test_backpressure();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain: %0d responses never arrived, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_bank_pingpong.md
WEIGHT_BANK_PINGPONG -- requirements
Module: weight_bank_pingpong

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of one weight word.
REQ-002 SHALL have parameter NUM_PES, default 3, meaning the number of PE lanes fed per read.
REQ-003 SHALL have parameter NUM_FILTERS, default 2, meaning the number of filters per bank.
REQ-004 SHALL have parameter NUM_CHANNELS, default 2, meaning the number of input channels per filter.
REQ-005 SHALL have parameter KERNEL_SIZE, default 3, meaning the number of taps per filter row.
REQ-006 SHALL define DEPTH = NUM_FILTERS*NUM_CHANNELS*KERNEL_SIZE entries per bank, each NUM_PES*DATA_WIDTH bits wide; AW = max(1, clog2(DEPTH)).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port wr_valid, input, 1 bit: the preload beat is valid.
REQ-010 SHALL have port wr_data, input, NUM_PES*DATA_WIDTH bits: one entry; lane p is at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port wr_ready, output, 1 bit: the shadow bank accepts a beat.
REQ-012 SHALL have port swap, input, 1 bit: request to promote the shadow bank to active.
REQ-013 SHALL have port rd_req, input, 1 bit: read one entry from the active bank.
REQ-014 SHALL have ports filter_id, channel_id and tap, inputs, widths max(1,clog2(NUM_FILTERS)), max(1,clog2(NUM_CHANNELS)) and max(1,clog2(KERNEL_SIZE)): the read coordinates.
REQ-015 SHALL have port rd_valid, output, 1 bit, and port rd_weights, output, NUM_PES*DATA_WIDTH bits: the read response, using the same lane packing as wr_data.
REQ-016 SHALL have ports active_valid, shadow_full and active_bank, outputs, 1 bit each: bank status.
REQ-017 SHALL have ports swap_err and rd_err, outputs, 1 bit each: single-cycle error pulses.

Function
REQ-018 SHALL contain two banks of DEPTH entries each; active_bank names the read bank, and the other bank is the shadow (write) bank.
REQ-019 SHALL run the write-side FSM with states EMPTY, FILL and FULL; wr_ready = 1 in EMPTY and FILL, 0 in FULL, and 0 while rst = 1.
REQ-020 SHALL treat wr_valid & wr_ready as an accepted beat; beat n (n = 0..DEPTH-1) writes shadow entry n, and the write counter increments per beat.
REQ-021 SHALL move the FSM EMPTY->FILL on the first accepted beat and ->FULL on the edge that accepts beat DEPTH-1 (EMPTY->FULL directly if DEPTH = 1); shadow_full = 1 exactly in FULL.
REQ-022 SHALL ignore wr_valid while in FULL, with no write and no counter change.
REQ-023 SHALL honour swap only when the FSM is in FULL at that edge; on a legal swap, the next edge toggles active_bank, sets active_valid = 1, and returns the FSM to EMPTY with the counter at 0.
REQ-024 SHALL NOT honour swap when the FSM is not in FULL, including the cycle that accepts the final beat; such a swap SHALL produce swap_err = 1 for one cycle with no state change.
REQ-025 SHALL compute the read index as (filter_id*NUM_CHANNELS + channel_id)*KERNEL_SIZE + tap.
REQ-026 SHALL handle rd_req = 1 with active_valid = 1 and all coordinates in range by asserting rd_valid = 1 on the next cycle, with rd_weights equal to that entry (latency 1, one response per request, back-to-back requests allowed).
REQ-027 SHALL respond to a rd_req with any coordinate out of range, or with active_valid = 0, by driving rd_valid = 1, rd_weights = 0 and rd_err = 1 on the next cycle.
REQ-028 SHALL hold rd_valid = 0 and rd_weights at 0 in cycles with no response.
REQ-029 SHALL serve a read that coincides with a legal swap from the pre-swap active bank.
REQ-030 SHALL never let writes alter the active bank; a read and a write in the same cycle are independent.

Reset
REQ-031 SHALL, on rst = 1 at a clock edge, set FSM = EMPTY, write counter = 0, active_bank = 0, active_valid = 0, rd_valid = 0, rd_weights = 0, swap_err = 0, rd_err = 0 and shadow_full = 0.
REQ-032 SHALL NOT clear the bank contents on reset; after reset, data becomes readable only following a complete fill and a swap.
REQ-033 SHALL treat rst asserted mid-fill or mid-read as discarding the partial fill and any pending response, with no rd_valid in the cycle after reset.

Verification
REQ-034 SHALL pass a fill-and-swap test (defaults, DEPTH = 12): write 12 beats with entry n = {n+200, n+100, n}, then pulse swap -> shadow_full 0->1 after beat 11, then active_bank = 1, active_valid = 1, wr_ready = 1.
REQ-035 SHALL pass a read-mapping test: read filter 1, channel 0, tap 2 (index 8) -> one cycle later rd_valid = 1 and rd_weights = {208, 108, 8}; read tap 3 -> rd_err = 1 and rd_weights = 0.
REQ-036 SHALL pass an illegal-swap test: swap after 5 beats -> swap_err pulse and active_bank unchanged; swap in the same cycle as beat 11 -> swap_err, then a swap one cycle later succeeds.
REQ-037 SHALL pass a ping-pong test: fill bank 1 with value 0x0AAA per lane while reading index 0 continuously, then swap on the same cycle as a read -> that read returns bank-0 data and the next read returns 0x0AAA in every lane.
REQ-038 SHALL pass a reset-mid-operation test: rst during beat 6 of a fill -> the post-reset read gives rd_err, 12 new beats are required before shadow_full = 1, and rd_valid = 0 in the first cycle after reset.
REQ-039 SHALL pass a backpressure test: wr_valid held high in FULL for 10 cycles -> wr_ready = 0 and the data read after the swap matches the first 12 beats only.
